// File: rtl/morse_stream_decoder.sv
// morse_stream_decoder: debounced single-key Morse timing, letter decode to ASCII, and a valid/ready letter FIFO
module morse_stream_decoder #(
    parameter int DEBOUNCE_CYC   = 16,
    parameter int DOT_MAX_CYC    = 5000,
    parameter int LETTER_GAP_CYC = 15000,
    parameter int MAX_SYMBOLS    = 5,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          button,
    input  logic                          send,
    input  logic                          out_ready,
    output logic [7:0]                    letter,
    output logic                          letter_valid,
    output logic                          symbol_strobe,
    output logic                          symbol_is_dash,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun
);
    localparam int DW = $clog2(DEBOUNCE_CYC) + 1;
    localparam int PW = $clog2(DOT_MAX_CYC + 1) + 1;
    localparam int GW = $clog2(LETTER_GAP_CYC) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYC - 1);
    localparam logic [PW-1:0] DOT_MAX   = PW'(DOT_MAX_CYC);
    localparam logic [PW-1:0] PRESS_SAT = PW'(DOT_MAX_CYC + 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(LETTER_GAP_CYC - 1);
    localparam logic [2:0]    SYM_MAX   = 3'(MAX_SYMBOLS);
    localparam logic [CW-1:0] FULL      = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, PRESS, GAP, CLOSE} state_t;

    logic [1:0]             btn_s_q;
    logic [2:0]             snd_s_q;
    logic                   deb_q, deb_prev_q;
    logic [DW-1:0]          deb_cnt_q;
    logic                   press_ev, rel_ev, send_ev;
    state_t                 state_q, state_d;
    logic [PW-1:0]          press_cnt_q, press_cnt_d;
    logic [GW-1:0]          gap_cnt_q, gap_cnt_d;
    logic [MAX_SYMBOLS-1:0] pat_q, pat_d;
    logic [2:0]             sym_cnt_q, sym_cnt_d;
    logic                   err_q, err_d;
    logic                   add_sym, is_dash, push, sym_full;
    logic                   strobe_q, dash_q;
    logic [5:0]             code;
    logic [7:0]             dec_lut, dec_char;
    logic [7:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [7:0]             letter_q, letter_d;
    logic                   valid_q, overrun_q, overrun_d;
    logic                   pop, full, wr;

    // Debounced level flips only after DEBOUNCE_CYC consecutive samples disagreeing with it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_s_q    <= '0;
            snd_s_q    <= '0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            deb_cnt_q  <= '0;
        end else begin
            btn_s_q    <= {btn_s_q[0], button};
            snd_s_q    <= {snd_s_q[1:0], send};
            deb_prev_q <= deb_q;
            if (btn_s_q[1] == deb_q) begin
                deb_cnt_q <= '0;
            end else if (deb_cnt_q == DEB_LAST) begin
                deb_q     <= btn_s_q[1];
                deb_cnt_q <= '0;
            end else begin
                deb_cnt_q <= deb_cnt_q + 1'b1;
            end
        end
    end

    assign press_ev = deb_q & ~deb_prev_q;
    assign rel_ev   = ~deb_q & deb_prev_q;
    assign send_ev  = snd_s_q[1] & ~snd_s_q[2];

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // A press in GAP takes priority over gap expiry or a send edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = press_ev ? PRESS : IDLE;
            PRESS:   state_d = rel_ev ? GAP : PRESS;
            GAP:     state_d = press_ev ? PRESS : (gap_cnt_q == GAP_LAST || send_ev) ? CLOSE : GAP;
            default: state_d = IDLE;
        endcase
    end

    // press_cnt_q lags the debounced press length by one at release, hence >= rather than >
    always_comb begin
        add_sym = state_q == PRESS && rel_ev;
        is_dash = press_cnt_q >= DOT_MAX;
        push    = state_q == CLOSE;
    end

    always_comb begin
        sym_full    = sym_cnt_q == SYM_MAX;
        press_cnt_d = state_q != PRESS ? '0 : press_cnt_q == PRESS_SAT ? press_cnt_q : press_cnt_q + 1'b1;
        gap_cnt_d   = state_q != GAP ? '0 : gap_cnt_q == GAP_LAST ? gap_cnt_q : gap_cnt_q + 1'b1;
        pat_d       = push ? '0 : (add_sym && !sym_full) ? (pat_q << 1) | MAX_SYMBOLS'(is_dash) : pat_q;
        sym_cnt_d   = push ? '0 : (add_sym && !sym_full) ? sym_cnt_q + 1'b1 : sym_cnt_q;
        err_d       = push ? 1'b0 : err_q | (add_sym && sym_full);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            press_cnt_q <= '0;
            gap_cnt_q   <= '0;
            pat_q       <= '0;
            sym_cnt_q   <= '0;
            err_q       <= 1'b0;
            strobe_q    <= 1'b0;
            dash_q      <= 1'b0;
        end else begin
            press_cnt_q <= press_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            pat_q       <= pat_d;
            sym_cnt_q   <= sym_cnt_d;
            err_q       <= err_d;
            strobe_q    <= add_sym;
            dash_q      <= add_sym ? is_dash : dash_q;
        end
    end

    // Leading-one code: a 1 marker above the used pattern bits makes each length unique
    always_comb begin
        code = 6'(pat_q) | (6'd1 << sym_cnt_q);
        case (code)
            6'b101:    dec_lut = 8'h41;
            6'b11000:  dec_lut = 8'h42;
            6'b11010:  dec_lut = 8'h43;
            6'b1100:   dec_lut = 8'h44;
            6'b10:     dec_lut = 8'h45;
            6'b10010:  dec_lut = 8'h46;
            6'b1110:   dec_lut = 8'h47;
            6'b10000:  dec_lut = 8'h48;
            6'b100:    dec_lut = 8'h49;
            6'b10111:  dec_lut = 8'h4A;
            6'b1101:   dec_lut = 8'h4B;
            6'b10100:  dec_lut = 8'h4C;
            6'b111:    dec_lut = 8'h4D;
            6'b110:    dec_lut = 8'h4E;
            6'b1111:   dec_lut = 8'h4F;
            6'b10110:  dec_lut = 8'h50;
            6'b11101:  dec_lut = 8'h51;
            6'b1010:   dec_lut = 8'h52;
            6'b1000:   dec_lut = 8'h53;
            6'b11:     dec_lut = 8'h54;
            6'b1001:   dec_lut = 8'h55;
            6'b10001:  dec_lut = 8'h56;
            6'b1011:   dec_lut = 8'h57;
            6'b11001:  dec_lut = 8'h58;
            6'b11011:  dec_lut = 8'h59;
            6'b11100:  dec_lut = 8'h5A;
            6'b111111: dec_lut = 8'h30;
            6'b101111: dec_lut = 8'h31;
            6'b100111: dec_lut = 8'h32;
            6'b100011: dec_lut = 8'h33;
            6'b100001: dec_lut = 8'h34;
            6'b100000: dec_lut = 8'h35;
            6'b110000: dec_lut = 8'h36;
            6'b111000: dec_lut = 8'h37;
            6'b111100: dec_lut = 8'h38;
            6'b111110: dec_lut = 8'h39;
            default:   dec_lut = 8'h3F;
        endcase
        dec_char = (err_q || sym_cnt_q > 3'd5) ? 8'h3F : dec_lut;
    end

    // The registered head is refreshed from the post-update pointers, so it stays put while stalled
    always_comb begin
        pop       = valid_q && out_ready;
        full      = cnt_q == FULL;
        wr        = push && (!full || pop);
        wr_ptr_d  = wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        cnt_d     = cnt_q + CW'(wr) - CW'(pop);
        letter_d  = cnt_d == '0 ? 8'h00 : (wr && rd_ptr_d == wr_ptr_q) ? dec_char : mem_q[rd_ptr_d];
        overrun_d = overrun_q | (push && full && !pop);
    end

    always_ff @(posedge clk) begin
        if (wr) mem_q[wr_ptr_q] <= dec_char;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            letter_q  <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            letter_q  <= letter_d;
            valid_q   <= cnt_d != '0;
            overrun_q <= overrun_d;
        end
    end

    assign letter         = letter_q;
    assign letter_valid   = valid_q;
    assign symbol_strobe  = strobe_q;
    assign symbol_is_dash = dash_q;
    assign fifo_count     = cnt_q;
    assign overrun        = overrun_q;
endmodule

// File: tb/tb_morse_stream_decoder.sv
// tb_morse_stream_decoder: randomized keying against a table-driven Morse model with a letter/symbol scoreboard
module tb_morse_stream_decoder;
    localparam int DEB = 2, DOT = 10, GAPC = 30, MAXS = 5, DEPTH = 4;

    logic       clk = 1'b0, rst_n = 1'b0, button = 1'b0, send = 1'b0, out_ready = 1'b0;
    logic [7:0] letter;
    logic       letter_valid, symbol_strobe, symbol_is_dash, overrun;
    logic [2:0] fifo_count;

    int         checks = 0, failures = 0;
    int         ready_mode = 0;
    logic [7:0] exp_q[$];
    bit         sym_q[$];
    bit         exp_overrun = 0;

    string morse_tab[36] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                             "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                             "..-", "...-", ".--", "-..-", "-.--", "--..",
                             "-----", ".----", "..---", "...--", "....-", ".....", "-....", "--...",
                             "---..", "----."};
    string chars = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";

    morse_stream_decoder #(
        .DEBOUNCE_CYC(DEB), .DOT_MAX_CYC(DOT), .LETTER_GAP_CYC(GAPC), .MAX_SYMBOLS(MAXS), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .button(button), .send(send), .out_ready(out_ready),
        .letter(letter), .letter_valid(letter_valid), .symbol_strobe(symbol_strobe),
        .symbol_is_dash(symbol_is_dash), .fifo_count(fifo_count), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        out_ready = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && letter_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_letter: got %0h expected none", letter);
            end else chk("letter", letter, exp_q.pop_front());
        end
    end

    always @(negedge clk) begin
        if (rst_n && symbol_strobe) begin
            if (sym_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_strobe: got dash=%0d expected none", symbol_is_dash);
            end else chk("symbol_is_dash", symbol_is_dash, sym_q.pop_front());
        end
    end

    function automatic logic [7:0] model_decode(string s);
        if (s.len() > MAXS) return 8'h3F;
        for (int i = 0; i < 36; i++) if (morse_tab[i] == s) return chars[i];
        return 8'h3F;
    endfunction

    task automatic tick(int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic key_sym(int len, int gap);
        button = 1'b1;
        tick(len);
        button = 1'b0;
        sym_q.push_back(len > DOT);
        tick(gap);
    endtask

    task automatic expect_letter(logic [7:0] c);
        if (exp_q.size() >= DEPTH) exp_overrun = 1;
        else exp_q.push_back(c);
    endtask

    task automatic end_letter(bit use_send);
        if (use_send) begin
            tick(4);
            send = 1'b1;
            tick(3);
            send = 1'b0;
            tick(12);
        end else tick(45);
    endtask

    task automatic key_letter(string s, bit use_send);
        for (int i = 0; i < s.len(); i++) begin
            int len;
            len = (s[i] == "-") ? int'($urandom_range(11, 24)) : int'($urandom_range(2, 10));
            key_sym(len, (i == s.len() - 1) ? 0 : int'($urandom_range(3, 10)));
        end
        expect_letter(model_decode(s));
        end_letter(use_send);
    endtask

    task automatic drain();
        ready_mode = 1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || letter_valid); i++) tick(1);
        chk("drain_pending", exp_q.size(), 0);
        chk("drain_valid", letter_valid, 0);
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, "_letter"}, letter, 0);
        chk({tag, "_valid"}, letter_valid, 0);
        chk({tag, "_strobe"}, symbol_strobe, 0);
        chk({tag, "_dash"}, symbol_is_dash, 0);
        chk({tag, "_count"}, fifo_count, 0);
        chk({tag, "_overrun"}, overrun, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit b_seq[12] = '{1, 0, 1, 0, 1, 1, 1, 1, 1, 0, 1, 0};
        tick(3);
        check_all_zero("reset");
        rst_n = 1'b1;
        tick(3);

        // A from exact durations, held unread
        key_sym(4, 6);
        key_sym(20, 0);
        expect_letter(8'h41);
        tick(40);
        chk("t1_valid", letter_valid, 1);
        chk("t1_count", fifo_count, 1);
        chk("t1_last_dash", symbol_is_dash, 1);
        drain();

        // D closed early by send; nothing further appears
        ready_mode = 0;
        key_letter("-..", 1);
        chk("t2_send_close", fifo_count, 1);
        tick(40);
        chk("t2_no_second", fifo_count, 1);
        drain();

        // dot/dash boundary: 10 cycles dot, 11 cycles dash
        key_sym(10, 5);
        key_sym(11, 0);
        expect_letter(8'h41);
        end_letter(0);
        drain();

        key_letter("......", 0);
        key_letter("-----", 1);
        drain();

        // overflow with consumer stalled
        ready_mode = 0;
        tick(2);
        key_letter(".", 0);
        key_letter("-", 0);
        key_letter("..", 1);
        key_letter("--", 0);
        key_letter("-.", 0);
        chk("t4_count", fifo_count, DEPTH);
        chk("t4_overrun", overrun, exp_overrun);
        chk("t4_head", letter, 8'h45);
        tick(5);
        chk("t4_head_stable", letter, 8'h45);
        chk("t4_valid_stable", letter_valid, 1);
        drain();
        chk("t4_overrun_sticky", overrun, 1);

        // bouncy key: only the stable run counts
        foreach (b_seq[i]) begin
            button = b_seq[i];
            tick(1);
        end
        button = 1'b0;
        sym_q.push_back(1'b0);
        expect_letter(8'h45);
        tick(45);
        drain();

        // reset mid-press with letters buffered
        ready_mode = 0;
        key_letter(".", 0);
        key_letter("-", 0);
        chk("t6_count_before", fifo_count, 2);
        button = 1'b1;
        tick(15);
        rst_n = 1'b0;
        button = 1'b0;
        tick(1);
        check_all_zero("t6_reset");
        rst_n = 1'b1;
        exp_q.delete();
        exp_overrun = 0;
        tick(3);
        key_letter(".", 0);
        drain();

        // random letters and junk patterns with a random consumer
        ready_mode = 2;
        for (int n = 0; n < 20; n++) begin
            string s;
            if ($urandom_range(0, 4) == 0) begin
                s = "";
                for (int k = $urandom_range(1, 7); k > 0; k--) begin
                    if ($urandom_range(0, 1) == 1) s = {s, "-"};
                    else s = {s, "."};
                end
            end else s = morse_tab[$urandom_range(0, 35)];
            key_letter(s, 1'($urandom_range(0, 1)));
        end
        drain();
        chk("sym_pending", sym_q.size(), 0);
        chk("final_overrun", overrun, exp_overrun);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
